// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage of the pipeline.
// Chooses between the ALU result and load data, commits the chosen value into
// the integer register file, serves the two decode-stage read ports with a
// write-through bypass, and counts committed writes for debug/perf use.
module wb_regfile #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_wb_regwrite,
  input  logic              mem_wb_memtoreg,
  input  logic [ADDR_W-1:0] mem_wb_register_rd,
  input  logic [XLEN-1:0]   alu_result_mem_wb,
  input  logic [XLEN-1:0]   read_data_mem_wb,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_commit,
  output logic [31:0]       wb_count
);

  // Architectural register array and committed-write counter.
  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic [XLEN-1:0] regs_d [REG_COUNT];
  logic [31:0]     wb_count_q;
  logic [31:0]     wb_count_d;

  // Writeback value selection and commit qualification.
  logic [XLEN-1:0] wb_sel;
  logic            rd_nonzero;
  logic            commit;

  // Choose load data or ALU result; x0 and reset both veto the commit.
  always_comb begin
    wb_sel     = mem_wb_memtoreg ? read_data_mem_wb : alu_result_mem_wb;
    rd_nonzero = (mem_wb_register_rd != '0);
    commit     = rst_n & mem_wb_regwrite & rd_nonzero;
  end

  // Next-state for the array and the counter; the counter wraps naturally.
  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (commit) begin
      regs_d[mem_wb_register_rd] = wb_sel;
      wb_count_d                 = wb_count_q + 32'd1;
    end
  end

  // State registers; reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Read port 1: x0 is zero, then bypass of this cycle's commit, then array.
  always_comb begin
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (commit && (rs1_addr == mem_wb_register_rd)) begin
      rs1_data = wb_sel;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (commit && (rs2_addr == mem_wb_register_rd)) begin
      rs2_data = wb_sel;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // Drive the observation outputs.
  always_comb begin
    wb_data   = wb_sel;
    wb_commit = commit;
    wb_count  = wb_count_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// plain array/counter model of the register file.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        mem_wb_regwrite;
  logic        mem_wb_memtoreg;
  logic [4:0]  mem_wb_register_rd;
  logic [31:0] alu_result_mem_wb;
  logic [31:0] read_data_mem_wb;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_commit;
  logic [31:0] wb_count;

  wb_regfile #(.XLEN(32), .REG_COUNT(32), .ADDR_W(5)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_wb_regwrite    (mem_wb_regwrite),
    .mem_wb_memtoreg    (mem_wb_memtoreg),
    .mem_wb_register_rd (mem_wb_register_rd),
    .alu_result_mem_wb  (alu_result_mem_wb),
    .read_data_mem_wb   (read_data_mem_wb),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .wb_data            (wb_data),
    .wb_commit          (wb_commit),
    .wb_count           (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state.
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the same inputs the DUT samples.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_count = 32'h0;
      chk_en  = 1'b1;
    end else if (mem_wb_regwrite && mem_wb_register_rd != 5'd0) begin
      m_regs[mem_wb_register_rd] = mem_wb_memtoreg ? read_data_mem_wb : alu_result_mem_wb;
      m_count = m_count + 32'd1;
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic cm, input logic [31:0] wv);
    if (a == 5'd0) return 32'h0;
    if (cm && a == mem_wb_register_rd) return wv;
    return m_regs[a];
  endfunction

  // Compare process: all outputs checked on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] e_wb;
      logic        e_cm;
      e_wb = mem_wb_memtoreg ? read_data_mem_wb : alu_result_mem_wb;
      e_cm = rst_n && mem_wb_regwrite && (mem_wb_register_rd != 5'd0);
      chk("wb_data", wb_data, e_wb);
      chk("wb_commit", {31'h0, wb_commit}, {31'h0, e_cm});
      chk("rs1_data", rs1_data, m_read(rs1_addr, e_cm, e_wb));
      chk("rs2_data", rs2_data, m_read(rs2_addr, e_cm, e_wb));
      chk("wb_count", wb_count, m_count);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic mtr, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld);
    mem_wb_regwrite    = we;
    mem_wb_memtoreg    = mtr;
    mem_wb_register_rd = rd;
    alu_result_mem_wb  = alu;
    read_data_mem_wb   = ld;
  endtask

  initial begin
    rst_n    = 1'b0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Reset clear.
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs1_addr = 5'd5;
    mid_cycle();
    chk("pre_reset_x5", rs1_data, 32'hDEADBEEF);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    mid_cycle();
    chk("reset_x5", rs1_data, 32'h0);
    chk("reset_count", wb_count, 32'h0);

    // Write then read, ALU and load paths.
    next_cycle();
    drive(1'b1, 1'b0, 5'd7, 32'h12345678, 32'hAAAAAAAA);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs2_addr = 5'd7;
    mid_cycle();
    chk("alu_x7", rs2_data, 32'h12345678);
    chk("count_1", wb_count, 32'd1);
    next_cycle();
    drive(1'b1, 1'b1, 5'd7, 32'h12345678, 32'hAAAAAAAA);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    mid_cycle();
    chk("load_x7", rs2_data, 32'hAAAAAAAA);
    chk("count_2", wb_count, 32'd2);

    // Same-cycle bypass on both ports.
    next_cycle();
    drive(1'b1, 1'b0, 5'd3, 32'h0000CAFE, 32'h0);
    rs1_addr = 5'd3;
    rs2_addr = 5'd3;
    mid_cycle();
    chk("bypass_rs1", rs1_data, 32'h0000CAFE);
    chk("bypass_rs2", rs2_data, 32'h0000CAFE);
    chk("bypass_commit", {31'h0, wb_commit}, 32'd1);

    // x0 protection.
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    rs1_addr = 5'd0;
    mid_cycle();
    chk("x0_during", rs1_data, 32'h0);
    chk("x0_commit", {31'h0, wb_commit}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    mid_cycle();
    chk("x0_after", rs1_data, 32'h0);
    chk("x0_count", wb_count, 32'd3);

    // Reset colliding with a write: stored value visible, write dropped.
    next_cycle();
    drive(1'b1, 1'b0, 5'd9, 32'h00000077, 32'h0);
    next_cycle();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 5'd9, 32'h00000055, 32'h0);
    rs1_addr = 5'd9;
    mid_cycle();
    chk("coll_during", rs1_data, 32'h00000077);
    chk("coll_commit", {31'h0, wb_commit}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    mid_cycle();
    chk("coll_x9", rs1_data, 32'h0);
    chk("coll_count", wb_count, 32'h0);

    // Randomized traffic, including occasional resets and address aliasing.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 99) > 1);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            $urandom, $urandom);
      rs1_addr = ($urandom_range(0, 2) == 0) ? mem_wb_register_rd : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
    end

    // Counter wrap: preload the counter to all-ones during an idle cycle.
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    #3;
    force dut.wb_count_q = 32'hFFFFFFFF;
    m_count = 32'hFFFFFFFF;
    @(negedge clk);
    #3;
    release dut.wb_count_q;
    mid_cycle();
    chk("wrap_pre", wb_count, 32'hFFFFFFFF);
    next_cycle();
    drive(1'b1, 1'b0, 5'd1, 32'h0BADF00D, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs1_addr = 5'd1;
    mid_cycle();
    chk("wrap_count", wb_count, 32'h0);
    chk("wrap_x1", rs1_data, 32'h0BADF00D);

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (ALU result or load data) and commits it to the 32x32 integer register file.
- Serves the two ID-stage read ports, with write-through bypass so the decode stage sees a same-cycle writeback.
- Keeps a committed-write counter for debug and performance use.

Parameters:
- XLEN, 32, data width of registers and datapaths.
- REG_COUNT, 32, number of architectural registers.
- ADDR_W, 5, register address width (log2 of REG_COUNT).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- mem_wb_regwrite  input  1  write enable from the MEM/WB register.
- mem_wb_memtoreg  input  1  1 selects load data, 0 selects ALU result.
- mem_wb_register_rd  input  ADDR_W  destination register.
- alu_result_mem_wb  input  XLEN  ALU result from MEM/WB.
- read_data_mem_wb  input  XLEN  load data from MEM/WB.
- rs1_addr  input  ADDR_W  ID read port 1 address.
- rs2_addr  input  ADDR_W  ID read port 2 address.
- rs1_data  output  XLEN  read port 1 data, combinational.
- rs2_data  output  XLEN  read port 2 data, combinational.
- wb_data  output  XLEN  selected writeback value, combinational.
- wb_commit  output  1  high when a write commits at the coming edge.
- wb_count  output  32  registered count of committed writes.

Behaviour:
- Reset
  - Synchronous, active-low. On a rising clk with rst_n=0, all REG_COUNT registers clear to 0 and wb_count clears to 0.
  - Reset has priority over any write presented in the same cycle; that write is dropped, not deferred.
- Writeback select
  - wb_data = mem_wb_memtoreg ? read_data_mem_wb : alu_result_mem_wb, purely combinational, zero latency.
- Commit condition
  - wb_commit = rst_n & mem_wb_regwrite & (mem_wb_register_rd != 0).
  - On a rising clk with wb_commit=1: regs[mem_wb_register_rd] <= wb_data and wb_count <= wb_count + 1.
  - wb_count wraps modulo 2^32 (0xFFFFFFFF -> 0x00000000), no saturation.
- Register x0
  - Hardwired zero. Writes to rd=0 are discarded and do not increment wb_count.
  - A read of address 0 always returns 0, including under bypass.
- Read ports (each independent, combinational)
  - If addr==0, data = 0.
  - Else if wb_commit=1 and addr==mem_wb_register_rd, data = wb_data (write-through bypass).
  - Else data = regs[addr].
- Simultaneous events
  - Both read ports may hit the bypass in the same cycle; both return wb_data.
  - rs1_addr==rs2_addr yields identical data on both ports.
- While rst_n=0
  - Bypass is disabled and reads return stored contents.
  - Contents read 0 from the cycle after the first reset edge.
- Latency
  - A committed value is visible through the bypass in the commit cycle, and from the array from the next cycle onward.
- No stall input. The block commits every cycle that MEM/WB presents regwrite; holding the pipeline is the MEM/WB register's responsibility.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, assert rst_n=0 for one edge, release -> rs1_addr=5 reads 0x00000000, wb_count=0.
- Write and read: regwrite=1, memtoreg=0, rd=7, alu=0x12345678, load=0xAAAAAAAA -> next cycle rs2_addr=7 reads 0x12345678, wb_count=1. Repeat with memtoreg=1 -> reads 0xAAAAAAAA, wb_count=2.
- Bypass: same-cycle regwrite=1, rd=3, alu=0x0000CAFE, rs1_addr=rs2_addr=3 -> both read 0x0000CAFE combinationally before the edge.
- x0 protection: regwrite=1, rd=0, alu=0xFFFFFFFF, rs1_addr=0 -> rs1_data=0 during and after, wb_commit=0, wb_count unchanged.
- Reset vs write collision: rst_n=0 with regwrite=1, rd=9, alu=0x55 -> after edge x9=0, wb_count=0; rs1_addr=9 during the reset cycle shows the stored value, not 0x55.
- Counter wrap: force wb_count to 0xFFFFFFFF via 2^32-1 commits (or backdoor), then one commit to rd=1 -> wb_count=0x00000000, x1 updated.
